// File: rtl/pc_redirect.sv
// Fetch PC register with branch/jump redirect and a timed pipeline flush.
// Optional accepted-redirect counter is enabled by defining PC_REDIRECT_CNT_EN.
module pc_redirect #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stall,
    input  logic        i_inst_compressed,
    input  logic        i_branch_taken,
    input  logic        i_jump,
    input  logic [31:0] i_target,
    output logic [31:0] o_pc,
    output logic        o_flush,
`ifdef PC_REDIRECT_CNT_EN
    output logic        o_redirect,
    output logic [31:0] o_redirect_count
`else
    output logic        o_redirect
`endif
);

    typedef enum logic {StIdle, StFlush} state_e;

    localparam logic [2:0] CntInit = 3'(FLUSH_CYCLES - 1);

    state_e      r_state, w_state_d;
    logic [2:0]  r_cnt, w_cnt_d;
    logic [31:0] r_pc, w_pc_d;
    logic        r_redirect, w_redirect_d;

    logic        w_req;
    logic        w_accept;
    logic [31:0] w_pc_inc;

    assign w_req    = i_branch_taken | i_jump;
    // Requests seen during a flush come from squashed instructions.
    assign w_accept = w_req & (r_state == StIdle);
    assign w_pc_inc = r_pc + (i_inst_compressed ? 32'd2 : 32'd4);

    always_comb begin
        w_state_d    = r_state;
        w_cnt_d      = r_cnt;
        w_pc_d       = r_pc;
        w_redirect_d = 1'b0;
        if (w_accept) begin
            w_pc_d       = {i_target[31:1], 1'b0};
            w_state_d    = StFlush;
            w_cnt_d      = CntInit;
            w_redirect_d = 1'b1;
        end else if (!i_stall) begin
            w_pc_d = w_pc_inc;
            if (r_state == StFlush) begin
                if (r_cnt == 3'd0) begin
                    w_state_d = StIdle;
                end else begin
                    w_cnt_d = r_cnt - 3'd1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_cnt      <= 3'd0;
            r_pc       <= RESET_PC;
            r_redirect <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_cnt      <= w_cnt_d;
            r_pc       <= w_pc_d;
            r_redirect <= w_redirect_d;
        end
    end

    assign o_pc       = r_pc;
    assign o_flush    = (r_state == StFlush);
    assign o_redirect = r_redirect;

`ifdef PC_REDIRECT_CNT_EN
    logic [31:0] r_redirect_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_redirect_count <= 32'd0;
        end else if (w_accept && (r_redirect_count != 32'hFFFF_FFFF)) begin
            r_redirect_count <= r_redirect_count + 32'd1;
        end
    end

    assign o_redirect_count = r_redirect_count;
`endif

endmodule

// File: tb/tb_pc_redirect.sv
// Directed self-checking bench for pc_redirect (default parameters).
// Define PC_REDIRECT_CNT_EN to also exercise the redirect counter.
module tb_pc_redirect;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        inst_compressed;
    logic        branch_taken;
    logic        jump;
    logic [31:0] target;
    logic [31:0] pc;
    logic        flush;
    logic        redirect;
`ifdef PC_REDIRECT_CNT_EN
    logic [31:0] redirect_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    pc_redirect dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_stall          (stall),
        .i_inst_compressed(inst_compressed),
        .i_branch_taken   (branch_taken),
        .i_jump           (jump),
        .i_target         (target),
        .o_pc             (pc),
        .o_flush          (flush),
`ifdef PC_REDIRECT_CNT_EN
        .o_redirect       (redirect),
        .o_redirect_count (redirect_count)
`else
        .o_redirect       (redirect)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; inst_compressed = 1'b0;
        branch_taken = 1'b0; jump = 1'b0; target = 32'h0;
        #12;
        n_vec++;
        if (pc !== 32'h0 || flush !== 1'b0 || redirect !== 1'b0) begin
            n_err++;
            $display("FAIL reset_init: pc=%h flush=%b redirect=%b, want 0/0/0", pc, flush, redirect);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) step();
        n_vec++;
        if (pc !== 32'h40) begin
            n_err++;
            $display("FAIL run_to_40: pc=%h, want 00000040", pc);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (pc !== 32'h0 || flush !== 1'b0 || redirect !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: pc=%h flush=%b redirect=%b, want 0/0/0", pc, flush, redirect);
        end
        rst_n = 1'b1;
        // Reset during a flush must abort it.
        jump = 1'b1; target = 32'h80;
        step();
        jump = 1'b0;
        n_vec++;
        if (pc !== 32'h80 || flush !== 1'b1) begin
            n_err++;
            $display("FAIL pre_abort: pc=%h flush=%b, want 00000080/1", pc, flush);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (pc !== 32'h0 || flush !== 1'b0 || redirect !== 1'b0) begin
            n_err++;
            $display("FAIL reset_abort_flush: pc=%h flush=%b redirect=%b, want 0/0/0", pc, flush, redirect);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [4];
        logic        comp   [3];
        exp_pc = '{32'h0, 32'h4, 32'h6, 32'hA};
        comp   = '{1'b0, 1'b1, 1'b0};
        n_vec++;
        if (pc !== exp_pc[0]) begin
            n_err++;
            $display("FAIL seq_start: pc=%h, want %h", pc, exp_pc[0]);
        end
        for (int i = 0; i < 3; i++) begin
            inst_compressed = comp[i];
            step();
            n_vec++;
            if (pc !== exp_pc[i+1] || flush !== 1'b0) begin
                n_err++;
                $display("FAIL seq_%0d: pc=%h flush=%b, want %h/0", i, pc, flush, exp_pc[i+1]);
            end
        end
        inst_compressed = 1'b0;
        stall = 1'b1;
        step();
        n_vec++;
        if (pc !== 32'hA) begin
            n_err++;
            $display("FAIL seq_stall: pc=%h, want 0000000a", pc);
        end
        stall = 1'b0;
        step();
        n_vec++;
        if (pc !== 32'hE) begin
            n_err++;
            $display("FAIL seq_resume: pc=%h, want 0000000e", pc);
        end
    endtask

    task automatic test_branch_stall_and_ignored();
        branch_taken = 1'b1; target = 32'h100; stall = 1'b1;
        step();
        branch_taken = 1'b0; stall = 1'b0;
        n_vec++;
        if (pc !== 32'h100 || redirect !== 1'b1 || flush !== 1'b1) begin
            n_err++;
            $display("FAIL br_n1: pc=%h redirect=%b flush=%b, want 00000100/1/1", pc, redirect, flush);
        end
        step();
        n_vec++;
        if (pc !== 32'h104 || redirect !== 1'b0 || flush !== 1'b1) begin
            n_err++;
            $display("FAIL br_n2: pc=%h redirect=%b flush=%b, want 00000104/0/1", pc, redirect, flush);
        end
        jump = 1'b1; target = 32'h300;
        step();
        jump = 1'b0;
        n_vec++;
        if (pc !== 32'h108 || redirect !== 1'b0 || flush !== 1'b0) begin
            n_err++;
            $display("FAIL ignored_req: pc=%h redirect=%b flush=%b, want 00000108/0/0", pc, redirect, flush);
        end
    endtask

    task automatic test_odd_and_wrap();
        jump = 1'b1; target = 32'h203;
        step();
        jump = 1'b0;
        n_vec++;
        if (pc !== 32'h202 || redirect !== 1'b1) begin
            n_err++;
            $display("FAIL odd_target: pc=%h redirect=%b, want 00000202/1", pc, redirect);
        end
        step(); step();
        n_vec++;
        if (pc !== 32'h20A || flush !== 1'b0) begin
            n_err++;
            $display("FAIL odd_follow: pc=%h flush=%b, want 0000020a/0", pc, flush);
        end
        // Both request sources at once: one redirect to the single target.
        branch_taken = 1'b1; jump = 1'b1; target = 32'hFFFF_FFFC;
        step();
        branch_taken = 1'b0; jump = 1'b0;
        n_vec++;
        if (pc !== 32'hFFFF_FFFC || redirect !== 1'b1) begin
            n_err++;
            $display("FAIL wrap4_target: pc=%h redirect=%b, want fffffffc/1", pc, redirect);
        end
        step();
        n_vec++;
        if (pc !== 32'h0) begin
            n_err++;
            $display("FAIL wrap4: pc=%h, want 00000000", pc);
        end
        step();
        jump = 1'b1; target = 32'hFFFF_FFFF;
        step();
        jump = 1'b0;
        n_vec++;
        if (pc !== 32'hFFFF_FFFE) begin
            n_err++;
            $display("FAIL wrap2_target: pc=%h, want fffffffe", pc);
        end
        inst_compressed = 1'b1;
        step();
        inst_compressed = 1'b0;
        n_vec++;
        if (pc !== 32'h0) begin
            n_err++;
            $display("FAIL wrap2: pc=%h, want 00000000", pc);
        end
        step();
    endtask

    task automatic test_stall_in_flush();
        jump = 1'b1; target = 32'h500;
        step();
        jump = 1'b0; stall = 1'b1;
        step(); step(); step();
        n_vec++;
        if (pc !== 32'h500 || flush !== 1'b1 || redirect !== 1'b0) begin
            n_err++;
            $display("FAIL flush_stall_hold: pc=%h flush=%b redirect=%b, want 00000500/1/0", pc, flush, redirect);
        end
        stall = 1'b0;
        step();
        n_vec++;
        if (pc !== 32'h504 || flush !== 1'b1) begin
            n_err++;
            $display("FAIL flush_stall_resume: pc=%h flush=%b, want 00000504/1", pc, flush);
        end
        step();
        n_vec++;
        if (pc !== 32'h508 || flush !== 1'b0) begin
            n_err++;
            $display("FAIL flush_stall_end: pc=%h flush=%b, want 00000508/0", pc, flush);
        end
        // First cycle with flush low accepts a new request.
        branch_taken = 1'b1; target = 32'h600;
        step();
        branch_taken = 1'b0;
        n_vec++;
        if (pc !== 32'h600 || redirect !== 1'b1 || flush !== 1'b1) begin
            n_err++;
            $display("FAIL back_to_back: pc=%h redirect=%b flush=%b, want 00000600/1/1", pc, redirect, flush);
        end
        step(); step();
    endtask

`ifdef PC_REDIRECT_CNT_EN
    task automatic test_counter();
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        n_vec++;
        if (redirect_count !== 32'd0) begin
            n_err++;
            $display("FAIL cnt_reset0: count=%0d, want 0", redirect_count);
        end
        branch_taken = 1'b1; target = 32'h10;
        step();
        branch_taken = 1'b0;
        step(); step();
        jump = 1'b1; target = 32'h20;
        step();
        step();
        jump = 1'b0;
        step();
        branch_taken = 1'b1; target = 32'h30;
        step();
        branch_taken = 1'b0;
        step(); step();
        n_vec++;
        if (redirect_count !== 32'd3) begin
            n_err++;
            $display("FAIL cnt_three: count=%0d, want 3", redirect_count);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (redirect_count !== 32'd0) begin
            n_err++;
            $display("FAIL cnt_reset: count=%0d, want 0", redirect_count);
        end
        rst_n = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_sequential();
        test_branch_stall_and_ignored();
        test_odd_and_wrap();
        test_stall_in_flush();
`ifdef PC_REDIRECT_CNT_EN
        test_counter();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_redirect.md
# pc_redirect

Program-counter register and control-flow redirect stage for the RV32IC core. It consumes the branch decision from the branch unit (`branch_taken`) and the jump indication from EX, and produces the fetch PC. It advances the PC by 2 or 4 bytes per fetched instruction. On a redirect it loads the target and drives a timed flush that squashes wrong-path instructions in the IF/ID and ID/EX pipeline registers.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `FLUSH_CYCLES`, default 2: number of cycles `flush` stays high per redirect. Legal range is 1..7.

- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `stall`  in  1  hazard stall; holds the PC and the flush counter.
- `inst_compressed`  in  1  the instruction fetched at `pc` is 16-bit.
- `branch_taken`  in  1  conditional branch resolved taken (from the branch unit).
- `jump`  in  1  JAL/JALR in EX.
- `target`  in  32  redirect target address.
- `pc`  out  32  current fetch address.
- `flush`  out  1  squash the IF/ID and ID/EX registers this cycle.
- `redirect`  out  1  one-cycle pulse marking the first cycle after an accepted redirect.
- `redirect_count`  out  32  accepted-redirect counter; only present with `PC_REDIRECT_CNT_EN`.

## Operation
- States:
  - IDLE: no flush in progress.
  - FLUSH: flush in progress, with a 3-bit counter `cnt`.
- Request: `req = branch_taken | jump`.
- Accept condition: `accept = req & (state == IDLE)`.
  - While in FLUSH, `req` comes from a squashed instruction and is ignored.
- IDLE, `accept`:
  - `pc <= {target[31:1], 1'b0}`; bit 0 is always forced to 0.
  - `state <= FLUSH`, `cnt <= FLUSH_CYCLES - 1`.
  - `redirect <= 1`.
  - A redirect is accepted even when `stall` = 1 in the same cycle; a redirect has priority over a stall.
- IDLE, no accept:
  - If `stall` = 1: PC holds.
  - Otherwise: `pc <= pc + (inst_compressed ? 2 : 4)`.
- FLUSH:
  - The PC advances or holds exactly as in IDLE, without redirect.
  - If `stall` = 0: when `cnt` = 0 go to IDLE, else `cnt <= cnt - 1`.
  - If `stall` = 1: `cnt` and `state` hold.
- `flush` = (state == FLUSH). It is registered, with no combinational path from the inputs.
- `redirect` is high for exactly one cycle after each accept. Otherwise it is 0.
- PC arithmetic is modulo 2^32: 0xFFFF_FFFC + 4 = 0x0000_0000, and 0xFFFF_FFFE + 2 = 0x0000_0000.
- Simultaneous `branch_taken` and `jump`: treated as one request and uses the single `target`.

## Timing
- Reset (`rst` low, asynchronous) forces:
  - `pc` = `RESET_PC`
  - `state` = IDLE, `cnt` = 0
  - `flush` = 0, `redirect` = 0, `redirect_count` = 0
- Reset asserted mid-flush aborts the flush immediately.
- Redirect latency: request in cycle N, then `pc` = target, `flush` = 1 and `redirect` = 1 in cycle N+1.
  - `flush` remains high for `FLUSH_CYCLES` unstalled cycles: cycles N+1..N+FLUSH_CYCLES when there are no stalls.
  - The earliest next accept is the first cycle in which `flush` = 0.
- Sequential PC increment takes one cycle per edge in which `stall` = 0.

## Configuration
- `PC_REDIRECT_CNT_EN` defined:
  - A 32-bit `redirect_count` register increments on each accepted redirect.
  - It saturates at 0xFFFF_FFFF and is cleared by reset.
  - It is exposed on the `redirect_count` port.
- `PC_REDIRECT_CNT_EN` undefined:
  - The register and the port are absent.
  - All other behaviour is identical.

## Test plan
- Reset: run to pc = 0x40, pull `rst` low between edges. `pc` must become 0x0 immediately, with `flush` = 0 and `redirect` = 0.
- Sequential fetch: `RESET_PC` = 0, `inst_compressed` = 0,1,0, no stall. `pc` = 0x0, 0x4, 0x6, 0xA. With `stall` = 1 for one cycle, `pc` repeats its value once.
- Branch under stall: `branch_taken` = 1, `target` = 0x100, `stall` = 1 in cycle N.
  - Cycle N+1: `pc` = 0x100, `redirect` = 1, `flush` = 1.
  - Cycle N+2: `flush` = 1, `redirect` = 0.
  - Cycle N+3: `flush` = 0.
- Ignored request: `jump` = 1 with `target` = 0x300 during cycle N+2 of the previous test. `pc` must continue 0x104, 0x108 with no new flush.
- Odd target and wrap:
  - `jump` with `target` = 0x203 gives `pc` = 0x202.
  - A redirect to 0xFFFF_FFFC, followed by a 4-byte fetch, gives `pc` = 0x0.
- With `PC_REDIRECT_CNT_EN`: three accepted redirects plus one request during flush give `redirect_count` = 3. After reset, `redirect_count` = 0.
